// File: rtl/imem_responder_pkg.sv
// Shared widths and FSM encoding for the halfword instruction fetch responder.
package imem_responder_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;
  localparam int WAIT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } state_t;

endpackage

// File: rtl/imem_responder_wait_counter.sv
// Saturating wait-state counter; done flags that the programmed number of extra cycles has elapsed.
module imem_wait_counter
  import imem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_STATES);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LIMIT);

endmodule

// File: rtl/imem_responder.sv
// Serves 16-bit instruction fetches from an 8-bit memory as two little-endian byte reads,
// with a one-entry last-fetch buffer so a repeated fetch is answered without stalling.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read_enable,
  input  logic [ADDR_W-1:0]  address,
  output logic               stall_memory,
  output logic [INSTR_W-1:0] instruction_in,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [BYTE_W-1:0]  mem_data,
  input  logic               mem_ready
);

  state_t              state;
  logic [INSTR_W-1:0]  buffer;
  logic [ADDR_W-2:0]   tag;
  logic                valid;
  logic                hit;
  logic                busy;
  logic                wait_done;
  logic                byte_done;
  logic                addr_lsb_unused;

  assign addr_lsb_unused = address[0];

  assign hit       = valid && (tag == address[ADDR_W-1:1]);
  assign busy      = (state != IDLE);
  assign byte_done = busy && wait_done && mem_ready;

  assign stall_memory   = busy || (read_enable && !hit);
  assign instruction_in = buffer;

  // The counter sits at zero while idle, so each byte phase starts its wait count fresh.
  imem_wait_counter #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (!busy || byte_done),
    .enable (busy),
    .done   (wait_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      buffer   <= '0;
      tag      <= '0;
      valid    <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_enable && !hit) begin
            tag      <= address[ADDR_W-1:1];
            valid    <= 1'b0;
            mem_rd   <= 1'b1;
            mem_addr <= {address[ADDR_W-1:1], 1'b0};
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          if (byte_done) begin
            buffer[BYTE_W-1:0] <= mem_data;
            mem_addr           <= {tag, 1'b1};
            state              <= RD_HI;
          end
        end
        RD_HI: begin
          // The access runs from the latched tag, so the requester may wander off meanwhile.
          if (byte_done) begin
            buffer[INSTR_W-1:BYTE_W] <= mem_data;
            valid                    <= 1'b1;
            mem_rd                   <= 1'b0;
            state                    <= IDLE;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: drivers queue expected fetches and byte addresses, negedge monitors check them.
module tb_imem_responder;

  typedef struct {
    logic [15:0] instr;
    int          stall;
  } exp_t;

  logic        clk;
  logic        reset;

  logic        read_enable0;
  logic [11:0] address0;
  logic        stall_memory0;
  logic [15:0] instruction_in0;
  logic        mem_rd0;
  logic [11:0] mem_addr0;
  logic [7:0]  mem_data0;
  logic        mem_ready0;

  logic        read_enable2;
  logic [11:0] address2;
  logic        stall_memory2;
  logic [15:0] instruction_in2;
  logic        mem_rd2;
  logic [11:0] mem_addr2;
  logic [7:0]  mem_data2;
  logic        mem_ready2;

  logic [7:0]  mem [0:4095];

  exp_t        exp_q0[$];
  exp_t        exp_q2[$];
  logic [11:0] addr_q0[$];

  int          tests;
  int          fails;
  int          stall_cnt0;
  int          stall_cnt2;

  imem_responder #(.WAIT_STATES(0)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .read_enable    (read_enable0),
    .address        (address0),
    .stall_memory   (stall_memory0),
    .instruction_in (instruction_in0),
    .mem_rd         (mem_rd0),
    .mem_addr       (mem_addr0),
    .mem_data       (mem_data0),
    .mem_ready      (mem_ready0)
  );

  imem_responder #(.WAIT_STATES(2)) u_dut_ws2 (
    .clk            (clk),
    .reset          (reset),
    .read_enable    (read_enable2),
    .address        (address2),
    .stall_memory   (stall_memory2),
    .instruction_in (instruction_in2),
    .mem_rd         (mem_rd2),
    .mem_addr       (mem_addr2),
    .mem_data       (mem_data2),
    .mem_ready      (mem_ready2)
  );

  assign mem_data0 = mem_rd0 ? mem[mem_addr0] : 8'h00;
  assign mem_data2 = mem_rd2 ? mem[mem_addr2] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Fetch results for the zero-wait-state instance.
  always @(negedge clk) begin
    if (!reset || !read_enable0) begin
      stall_cnt0 = 0;
    end else if (stall_memory0) begin
      stall_cnt0++;
    end else begin
      if (exp_q0.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_fetch0: got 0x%0h, expected no fetch", instruction_in0);
      end else begin
        exp_t e;
        e = exp_q0.pop_front();
        check_output("instr0", instruction_in0, e.instr);
        check_output("stall_cycles0", stall_cnt0, e.stall);
        check_output("mem_rd_at_accept0", mem_rd0, 1'b0);
      end
      stall_cnt0 = 0;
    end
  end

  // Fetch results for the two-wait-state instance.
  always @(negedge clk) begin
    if (!reset || !read_enable2) begin
      stall_cnt2 = 0;
    end else if (stall_memory2) begin
      stall_cnt2++;
    end else begin
      if (exp_q2.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_fetch2: got 0x%0h, expected no fetch", instruction_in2);
      end else begin
        exp_t e;
        e = exp_q2.pop_front();
        check_output("instr2", instruction_in2, e.instr);
        check_output("stall_cycles2", stall_cnt2, e.stall);
      end
      stall_cnt2 = 0;
    end
  end

  // With zero wait states every ready read cycle is a byte capture.
  always @(negedge clk) begin
    if (reset && mem_rd0 && mem_ready0) begin
      if (addr_q0.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_mem_read0: got 0x%0h, expected no read", mem_addr0);
      end else begin
        check_output("mem_addr0", mem_addr0, addr_q0.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input bit use_ws2, input logic [11:0] addr,
                                input logic [15:0] exp_instr, input int exp_stall, input bit miss);
    exp_t e;
    bit   accepted;
    e.instr = exp_instr;
    e.stall = exp_stall;
    if (use_ws2) begin
      exp_q2.push_back(e);
    end else begin
      exp_q0.push_back(e);
      if (miss) begin
        addr_q0.push_back({addr[11:1], 1'b0});
        addr_q0.push_back({addr[11:1], 1'b1});
      end
    end
    @(posedge clk);
    #1;
    if (use_ws2) begin
      read_enable2 = 1'b1;
      address2     = addr;
    end else begin
      read_enable0 = 1'b1;
      address0     = addr;
    end
    accepted = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!(use_ws2 ? stall_memory2 : stall_memory0)) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("[TB] FAIL fetch_timeout: got no response for 0x%0h, expected one within 60 cycles", addr);
    end
    @(posedge clk);
    #1;
    read_enable0 = 1'b0;
    read_enable2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected one before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    tests        = 0;
    fails        = 0;
    stall_cnt0   = 0;
    stall_cnt2   = 0;
    reset        = 1'b0;
    read_enable0 = 1'b0;
    address0     = '0;
    mem_ready0   = 1'b1;
    read_enable2 = 1'b0;
    address2     = '0;
    mem_ready2   = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h34;  mem[12'h101] = 8'h12;
    mem[12'h0A0] = 8'h11;  mem[12'h0A1] = 8'h22;
    mem[12'h200] = 8'h78;  mem[12'h201] = 8'h56;
    mem[12'h300] = 8'hEF;  mem[12'h301] = 8'hBE;
    mem[12'hFFE] = 8'hCD;  mem[12'hFFF] = 8'hAB;

    // Reset values, and every request stalls while reset is held.
    #12;
    check_output("reset_stall_idle", stall_memory0, 1'b0);
    read_enable0 = 1'b1;
    address0     = 12'h100;
    #1;
    check_output("reset_stall_req", stall_memory0, 1'b1);
    check_output("reset_instr", instruction_in0, 16'h0000);
    check_output("reset_mem_rd", mem_rd0, 1'b0);
    check_output("reset_mem_addr", mem_addr0, 12'h000);
    read_enable0 = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;

    apply_stimulus(0, 12'h100, 16'h1234, 3, 1);
    apply_stimulus(0, 12'h101, 16'h1234, 0, 0);

    // Memory holds off ready for the first four low-byte cycles.
    mem_ready0 = 1'b0;
    fork
      apply_stimulus(0, 12'h0A0, 16'h2211, 7, 1);
      begin
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        mem_ready0 = 1'b1;
      end
    join

    // Requester abandons a miss; the access still completes into the buffer.
    addr_q0.push_back(12'h300);
    addr_q0.push_back(12'h301);
    @(posedge clk);
    #1;
    read_enable0 = 1'b1;
    address0     = 12'h300;
    @(posedge clk);
    #1;
    read_enable0 = 1'b0;
    address0     = 12'h400;
    repeat (4) @(posedge clk);
    apply_stimulus(0, 12'h301, 16'hBEEF, 0, 0);

    apply_stimulus(0, 12'hFFE, 16'hABCD, 3, 1);
    apply_stimulus(0, 12'hFFF, 16'hABCD, 0, 0);

    // Reset pulse during the high-byte read aborts the fill.
    addr_q0.push_back(12'h200);
    addr_q0.push_back(12'h201);
    @(posedge clk);
    #1;
    read_enable0 = 1'b1;
    address0     = 12'h200;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd0 && mem_addr0 == 12'h201) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("reached_rd_hi", seen, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check_output("abort_mem_rd", mem_rd0, 1'b0);
    check_output("abort_instr", instruction_in0, 16'h0000);
    check_output("abort_stall_req", stall_memory0, 1'b1);
    read_enable0 = 1'b0;
    #1;
    check_output("abort_stall_idle", stall_memory0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    apply_stimulus(0, 12'h100, 16'h1234, 3, 1);

    // Two wait states stretch each byte phase to three cycles.
    apply_stimulus(1, 12'h100, 16'h1234, 7, 1);
    apply_stimulus(1, 12'h101, 16'h1234, 0, 0);
    apply_stimulus(1, 12'hFFE, 16'hABCD, 7, 1);

    repeat (3) @(posedge clk);
    check_output("pending_fetch0", exp_q0.size(), 0);
    check_output("pending_fetch2", exp_q2.size(), 0);
    check_output("pending_mem_addr0", addr_q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
